// File: rtl/multi_digit_seven_segment_ctrl_if.sv
// Load handshake and segment bus for the N-digit seven-segment controller.
interface multi_digit_seven_segment_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load_i;
    logic [4*NUM_DIGITS-1:0] value_i;
    logic                    blank_lz_i;
    logic [NUM_DIGITS-1:0]   blink_mask_i;
    logic                    ready_o;
    logic                    done_o;
    logic [7*NUM_DIGITS-1:0] seg_o;

    modport master (
        output load_i, value_i, blank_lz_i, blink_mask_i,
        input  ready_o, done_o, seg_o
    );

    modport slave (
        input  load_i, value_i, blank_lz_i, blink_mask_i,
        output ready_o, done_o, seg_o
    );
endinterface

// File: rtl/multi_digit_seven_segment_ctrl.sv
// N-digit hex to seven-segment controller: digit-serial decode, atomic display update.
// Optional per-digit blink is compiled in with the SEVEN_SEG_BLINK_EN macro.
module multi_digit_seven_segment_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    multi_digit_seven_segment_ctrl_if.slave       bus
);
    localparam int                 IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]   IDX_TOP = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]         POL     = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
    localparam logic [6:0]         BLANK   = 7'h7F ^ POL;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] pat;
        case (d)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h18;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    lead_q;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic                    blank_lz_q;
    logic [7*NUM_DIGITS-1:0] work_q;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic                    ready_q;
    logic                    done_q;

    logic [3:0] cur_digit_d;
    logic       digit_blank_d;
    logic [6:0] digit_pat_d;

    assign cur_digit_d   = value_q[idx_q*4 +: 4];
    // Digit 0 is exempt so an all-zero word still shows a single "0".
    assign digit_blank_d = blank_lz_q && lead_q && (cur_digit_d == 4'd0) && (idx_q != '0);
    assign digit_pat_d   = (digit_blank_d ? 7'h7F : decode(cur_digit_d)) ^ POL;

`ifdef SEVEN_SEG_BLINK_EN
    logic [NUM_DIGITS-1:0] mask_q;
    logic [NUM_DIGITS-1:0] mask_live_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            lead_q     <= 1'b0;
            value_q    <= '0;
            blank_lz_q <= 1'b0;
            work_q     <= {NUM_DIGITS{BLANK}};
            seg_q      <= {NUM_DIGITS{BLANK}};
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
            mask_q      <= '0;
            mask_live_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load_i) begin
                        value_q    <= bus.value_i;
                        blank_lz_q <= bus.blank_lz_i;
`ifdef SEVEN_SEG_BLINK_EN
                        mask_q     <= bus.blink_mask_i;
`endif
                        idx_q      <= IDX_TOP;
                        lead_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= CONVERT;
                    end
                end
                CONVERT: begin
                    work_q[idx_q*7 +: 7] <= digit_pat_d;
                    if (cur_digit_d != 4'd0) begin
                        lead_q <= 1'b0;
                    end
                    if (idx_q == '0) begin
                        state_q <= UPDATE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                UPDATE: begin
                    seg_q   <= work_q;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
`ifdef SEVEN_SEG_BLINK_EN
                    mask_live_q <= mask_q;
`endif
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.done_o  = done_q;

`ifdef SEVEN_SEG_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt_q;
    logic             blink_phase_q;

    // Free-running: loads never restart the blink cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blink
        assign bus.seg_o[gi*7 +: 7] = (blink_phase_q && mask_live_q[gi]) ? BLANK : seg_q[gi*7 +: 7];
    end
`else
    assign bus.seg_o = seg_q;
`endif
endmodule

// File: tb/tb_multi_digit_seven_segment_ctrl.sv
// Directed self-checking bench: 8-digit active-low instance plus 1-digit active-high instance.
module tb_multi_digit_seven_segment_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multi_digit_seven_segment_ctrl_if #(.NUM_DIGITS(8)) bus8();
    multi_digit_seven_segment_ctrl_if #(.NUM_DIGITS(1)) bus1();

    multi_digit_seven_segment_ctrl #(.NUM_DIGITS(8), .ACTIVE_LOW(1), .BLINK_DIV(4)) u_dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );
    multi_digit_seven_segment_ctrl #(.NUM_DIGITS(1), .ACTIVE_LOW(0), .BLINK_DIV(4)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        string       name;
        logic [31:0] value;
        logic        lz;
        logic [55:0] exp_seg;
    } vec_t;

    localparam logic [55:0] BLANK8 = {8{7'h7F}};
    localparam logic [55:0] EXP_A  = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [55:0] EXP_B  = {7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic run8(input string name, input logic [31:0] v, input logic lz,
                        input logic [7:0] mask, input logic [55:0] exp);
        logic [55:0] prev;
        int          cyc;
        bit          seen;
        bit          changed;
        @(negedge clk);
        check({name, " ready_before"}, 64'(bus8.ready_o), 64'd1);
        prev = bus8.seg_o;
        bus8.load_i       = 1'b1;
        bus8.value_i      = v;
        bus8.blank_lz_i   = lz;
        bus8.blink_mask_i = mask;
        @(negedge clk);
        bus8.load_i  = 1'b0;
        bus8.value_i = ~v;
        cyc = 0; seen = 0; changed = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({name, " ready_busy"}, 64'(bus8.ready_o), 64'd0);
            if (bus8.done_o) seen = 1;
            else if (bus8.seg_o !== prev) changed = 1;
        end
        check({name, " latency"}, 64'(cyc), 64'd9);
        check({name, " no_partial"}, 64'(changed), 64'd0);
        check({name, " seg"}, 64'(bus8.seg_o), 64'(exp));
        check({name, " ready_at_done"}, 64'(bus8.ready_o), 64'd1);
        @(negedge clk);
        check({name, " done_pulse"}, 64'(bus8.done_o), 64'd0);
        check({name, " seg_hold"}, 64'(bus8.seg_o), 64'(exp));
    endtask

    task automatic run1(input string name, input logic [3:0] v, input logic lz, input logic [6:0] exp);
        int cyc;
        bit seen;
        @(negedge clk);
        bus1.load_i     = 1'b1;
        bus1.value_i    = v;
        bus1.blank_lz_i = lz;
        @(negedge clk);
        bus1.load_i = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus1.done_o) seen = 1;
        end
        check({name, " latency"}, 64'(cyc), 64'd2);
        check({name, " seg"}, 64'(bus1.seg_o), 64'(exp));
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{"hex_mix",      32'h0123ABCD, 1'b0, EXP_A};
        vecs[1] = '{"lz_f0",        32'h000000F0, 1'b1, {{6{7'h7F}}, 7'h0E, 7'h40}};
        vecs[2] = '{"lz_zero",      32'h00000000, 1'b1, {{7{7'h7F}}, 7'h40}};
        vecs[3] = '{"zero_nolz",    32'h00000000, 1'b0, {8{7'h40}}};
        vecs[4] = '{"hex_high",     32'h89ABCDEF, 1'b0, EXP_B};
        vecs[5] = '{"lz_inner0",    32'h00100007, 1'b1, {7'h7F, 7'h7F, 7'h79, {4{7'h40}}, 7'h78}};
        vecs[6] = '{"lz_top_digit", 32'h10000000, 1'b1, {7'h79, {7{7'h40}}}};

        bus8.load_i = 1'b0; bus8.value_i = '0; bus8.blank_lz_i = 1'b0; bus8.blink_mask_i = '0;
        bus1.load_i = 1'b0; bus1.value_i = '0; bus1.blank_lz_i = 1'b0; bus1.blink_mask_i = '0;

        repeat (3) @(negedge clk);
        check("reset seg8", 64'(bus8.seg_o), 64'(BLANK8));
        check("reset ready8", 64'(bus8.ready_o), 64'd1);
        check("reset done8", 64'(bus8.done_o), 64'd0);
        check("reset seg1_active_high", 64'(bus1.seg_o), 64'h00);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run8(vecs[i].name, vecs[i].value, vecs[i].lz, 8'h00, vecs[i].exp_seg);
        end

        // Asynchronous reset in the middle of a conversion
        begin
            int dcount;
            @(negedge clk);
            bus8.load_i = 1'b1; bus8.value_i = 32'h12345678; bus8.blank_lz_i = 1'b0;
            @(negedge clk);
            bus8.load_i = 1'b0;
            repeat (3) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            check("midrun_reset seg", 64'(bus8.seg_o), 64'(BLANK8));
            check("midrun_reset ready", 64'(bus8.ready_o), 64'd1);
            check("midrun_reset done", 64'(bus8.done_o), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            dcount = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (bus8.done_o) dcount++;
            end
            check("midrun_reset no_done", 64'(dcount), 64'd0);
            check("midrun_reset seg_stays", 64'(bus8.seg_o), 64'(BLANK8));
        end

        // load_i held through CONVERT: first word only, second taken on next IDLE
        begin
            int          d1, d2, dcount;
            logic [55:0] s1, s2;
            d1 = -1; d2 = -1; dcount = 0; s1 = '0; s2 = '0;
            @(negedge clk);
            bus8.load_i = 1'b1; bus8.value_i = 32'h0123ABCD; bus8.blank_lz_i = 1'b0;
            @(negedge clk);
            bus8.value_i = 32'h89ABCDEF;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (c == 1) check("b2b ready_busy", 64'(bus8.ready_o), 64'd0);
                if (c == 2) bus8.value_i = 32'hFFFFFFFF;
                if (c == 5) bus8.value_i = 32'h89ABCDEF;
                if (bus8.done_o) begin
                    dcount++;
                    if (d1 < 0) begin d1 = c; s1 = bus8.seg_o; end
                    else begin d2 = c; s2 = bus8.seg_o; bus8.load_i = 1'b0; end
                end
            end
            bus8.load_i = 1'b0;
            check("b2b first_done", 64'(d1), 64'd9);
            check("b2b spacing", 64'(d2 - d1), 64'd10);
            check("b2b done_count", 64'(dcount), 64'd2);
            check("b2b first_seg", 64'(s1), 64'(EXP_A));
            check("b2b second_seg", 64'(s2), 64'(EXP_B));
        end

        run1("al0_eight", 4'h8, 1'b0, 7'h7F);
        run1("al0_zero_lz", 4'h0, 1'b1, 7'h3F);
        run1("al0_one", 4'h1, 1'b0, 7'h06);
        run1("al0_b", 4'hB, 1'b0, 7'h7C);

`ifdef SEVEN_SEG_BLINK_EN
        begin
            logic [6:0] d0, first, other;
            int         f;
            run8("blink_load", 32'h5, 1'b0, 8'h00, {{7{7'h40}}, 7'h12});
            @(negedge clk);
            bus8.load_i = 1'b1; bus8.value_i = 32'h5; bus8.blank_lz_i = 1'b0; bus8.blink_mask_i = 8'h01;
            @(negedge clk);
            bus8.load_i = 1'b0;
            repeat (12) @(negedge clk);
            first = bus8.seg_o[6:0];
            other = (first == 7'h12) ? 7'h7F : 7'h12;
            f = -1;
            for (int c = 0; c < 6 && f < 0; c++) begin
                @(negedge clk);
                if (bus8.seg_o[6:0] !== first) f = c;
            end
            check("blink found_edge", 64'(f >= 0), 64'd1);
            for (int k = 0; k < 16; k++) begin
                d0 = (((k / 4) % 2) == 0) ? other : first;
                check("blink digit0", 64'(bus8.seg_o[6:0]), 64'(d0));
                check("blink others", 64'(bus8.seg_o[55:7]), 64'({7{7'h40}}));
                @(negedge clk);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
